// File: rtl/bimodal_branch_predictor_if.sv
// Fetch/execute-facing bundle of the bimodal branch predictor.
// master: pipeline side (drives fetch PC and resolved branches).
// slave : predictor side (returns prediction and statistics).
interface bimodal_branch_predictor_if #(
  parameter int PC_WIDTH = 32
);
  // fetch-side lookup
  logic [PC_WIDTH-1:0] fetchPc;
  logic                predTaken;
  logic [PC_WIDTH-1:0] predTarget;
  logic                predHit;
  // execute-side resolution
  logic                exValid;
  logic                exIsBranch;
  logic                exBranchTaken;
  logic                exPredTaken;
  logic [PC_WIDTH-1:0] exPc;
  logic [PC_WIDTH-1:0] exTarget;
  // statistics
  logic [31:0]         branchCount;
  logic [31:0]         mispredCount;

  modport master (
    output fetchPc, exValid, exIsBranch, exBranchTaken, exPredTaken, exPc, exTarget,
    input  predTaken, predTarget, predHit, branchCount, mispredCount
  );

  modport slave (
    input  fetchPc, exValid, exIsBranch, exBranchTaken, exPredTaken, exPc, exTarget,
    output predTaken, predTarget, predHit, branchCount, mispredCount
  );
endinterface

// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor: direct-mapped PHT of 2-bit saturating counters
// plus a direct-mapped BTB sharing the PC index, with saturating branch and
// misprediction counters.
// Optional: define GSHARE_EN to XOR a global history register into the PHT
// index (BTB indexing is unchanged).
module bimodal_branch_predictor #(
  parameter int         INDEX_WIDTH  = 6,
  parameter int         PC_WIDTH     = 32,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input logic                      clk,
  input logic                      rst,   // asynchronous, active low
  bimodal_branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_W   = PC_WIDTH - INDEX_WIDTH - 2;

  typedef logic [INDEX_WIDTH-1:0] idx_t;
  typedef logic [TAG_W-1:0]       tag_t;

  // state
  logic [ENTRIES-1:0][1:0]          pht_q,     pht_d;
  logic [ENTRIES-1:0]               btb_vld_q, btb_vld_d;
  logic [ENTRIES-1:0][TAG_W-1:0]    btb_tag_q, btb_tag_d;
  logic [ENTRIES-1:0][PC_WIDTH-1:0] btb_tgt_q, btb_tgt_d;
  logic [31:0]                      branch_cnt_q, branch_cnt_d;
  logic [31:0]                      mispred_cnt_q, mispred_cnt_d;

  // index / tag extraction; PC bits [1:0] are word-offset and never used
  idx_t f_btb_idx, u_btb_idx, f_pht_idx, u_pht_idx;
  tag_t f_tag, u_tag;
  logic upd;
  logic unused_pc_lsbs;

  assign f_btb_idx      = bp.fetchPc[INDEX_WIDTH+1:2];
  assign u_btb_idx      = bp.exPc[INDEX_WIDTH+1:2];
  assign f_tag          = bp.fetchPc[PC_WIDTH-1:INDEX_WIDTH+2];
  assign u_tag          = bp.exPc[PC_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_lsbs = ^{bp.fetchPc[1:0], bp.exPc[1:0]};

  // exValid gates everything, so X on the other ex* inputs is harmless
  assign upd = bp.exValid & bp.exIsBranch;

`ifdef GSHARE_EN
  idx_t ghr_q, ghr_d;

  // prediction and update both hash with the pre-shift history
  assign f_pht_idx = f_btb_idx ^ ghr_q;
  assign u_pht_idx = u_btb_idx ^ ghr_q;

  // shift resolved direction into the global history on every update
  always_comb begin
    ghr_d = ghr_q;
    if (upd) ghr_d = {ghr_q[INDEX_WIDTH-2:0], bp.exBranchTaken};
  end

  // global history register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end
`else
  assign f_pht_idx = f_btb_idx;
  assign u_pht_idx = u_btb_idx;
`endif

  // lookup reads registered state only: same-cycle updates show next cycle
  always_comb begin
    bp.predHit    = btb_vld_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
    bp.predTarget = btb_tgt_q[f_btb_idx];
    bp.predTaken  = bp.predHit && pht_q[f_pht_idx][1];
  end

  assign bp.branchCount  = branch_cnt_q;
  assign bp.mispredCount = mispred_cnt_q;

  // next state: counter train, BTB fill on taken, saturating statistics
  always_comb begin
    pht_d         = pht_q;
    btb_vld_d     = btb_vld_q;
    btb_tag_d     = btb_tag_q;
    btb_tgt_d     = btb_tgt_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      if (bp.exBranchTaken) begin
        if (pht_q[u_pht_idx] != 2'b11) pht_d[u_pht_idx] = pht_q[u_pht_idx] + 2'd1;
        // direct-mapped: a taken branch always claims its slot
        btb_vld_d[u_btb_idx] = 1'b1;
        btb_tag_d[u_btb_idx] = u_tag;
        btb_tgt_d[u_btb_idx] = bp.exTarget;
      end else begin
        if (pht_q[u_pht_idx] != 2'b00) pht_d[u_pht_idx] = pht_q[u_pht_idx] - 2'd1;
      end
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 32'd1;
      if ((bp.exBranchTaken != bp.exPredTaken) && (mispred_cnt_q != '1))
        mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // state registers; targets are cleared too so predTarget reads 0 after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pht_q         <= {ENTRIES{COUNTER_INIT}};
      btb_vld_q     <= '0;
      btb_tag_q     <= '0;
      btb_tgt_q     <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pht_q         <= pht_d;
      btb_vld_q     <= btb_vld_d;
      btb_tag_q     <= btb_tag_d;
      btb_tgt_q     <= btb_tgt_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Directed bench for bimodal_branch_predictor with hand-computed expectations.
module tb_bimodal_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  bimodal_branch_predictor_if #(.PC_WIDTH(32)) bp_if ();

  bimodal_branch_predictor #(
    .INDEX_WIDTH (6),
    .PC_WIDTH    (32),
    .COUNTER_INIT(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input logic hit, input logic tk, input logic [31:0] tgt);
    chk({tag, ".hit"}, {31'd0, bp_if.predHit}, {31'd0, hit});
    chk({tag, ".taken"}, {31'd0, bp_if.predTaken}, {31'd0, tk});
    if (hit) chk({tag, ".target"}, bp_if.predTarget, tgt);
  endtask

  task automatic chk_cnt(input string tag, input int bc, input int mp);
    chk({tag, ".branchCount"}, bp_if.branchCount, bc);
    chk({tag, ".mispredCount"}, bp_if.mispredCount, mp);
  endtask

  // one resolved branch, presented for exactly one posedge
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pd);
    @(negedge clk);
    bp_if.exValid       = 1'b1;
    bp_if.exIsBranch    = 1'b1;
    bp_if.exBranchTaken = tk;
    bp_if.exPredTaken   = pd;
    bp_if.exPc          = pc;
    bp_if.exTarget      = tgt;
    @(posedge clk);
    #1;
    bp_if.exValid    = 1'b0;
    bp_if.exIsBranch = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bp_if.fetchPc = pc;
    #1;
  endtask

  initial begin
    bp_if.fetchPc       = 32'h100;
    bp_if.exValid       = 1'b0;
    bp_if.exIsBranch    = 1'b0;
    bp_if.exBranchTaken = 1'b0;
    bp_if.exPredTaken   = 1'b0;
    bp_if.exPc          = '0;
    bp_if.exTarget      = '0;

    // reset state, during and after reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in.target", bp_if.predTarget, 32'h0);
    chk_pred("rst_in", 1'b0, 1'b0, 32'h0);
    chk_cnt("rst_in", 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out.target", bp_if.predTarget, 32'h0);
    chk_pred("rst_out", 1'b0, 1'b0, 32'h0);
    chk_cnt("rst_out", 0, 0);

`ifdef GSHARE_EN
    // taken at 0x100 with ghr=0 trains pht[0] 01->10, ghr becomes 1;
    // fetch 0x100 now hashes to pht[1] which is still 01
    resolve(32'h100, 1'b1, 32'h200, 1'b0);
    fetch(32'h100);
    chk_pred("gshare", 1'b1, 1'b0, 32'h200);
    chk_cnt("gshare", 1, 1);
    // taken at 0x104 (idx1 ^ ghr1 = pht[0]) -> pht[0]=11, ghr=3;
    // fetch 0x10C (idx3 ^ 3 = 0) misses the BTB so still not-taken
    resolve(32'h104, 1'b1, 32'h300, 1'b1);
    fetch(32'h104);
    chk_pred("gshare2", 1'b1, 1'b0, 32'h300);
    fetch(32'h10C);
    chk_pred("gshare3", 1'b0, 1'b0, 32'h0);
    chk_cnt("gshare3", 2, 1);
`else
    // same-cycle read/update: old value now, new value next cycle
    @(negedge clk);
    fetch(32'h100);
    bp_if.exValid       = 1'b1;
    bp_if.exIsBranch    = 1'b1;
    bp_if.exBranchTaken = 1'b1;
    bp_if.exPredTaken   = 1'b0;
    bp_if.exPc          = 32'h100;
    bp_if.exTarget      = 32'h200;
    #1;
    chk_pred("same_cyc", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    bp_if.exValid    = 1'b0;
    bp_if.exIsBranch = 1'b0;
    chk_pred("first_upd", 1'b1, 1'b1, 32'h200);   // counter 01->10
    chk_cnt("first_upd", 1, 1);

    // counter 10 -> 11 and holds through further taken updates
    repeat (4) resolve(32'h100, 1'b1, 32'h200, 1'b1);
    chk_pred("sat_hi", 1'b1, 1'b1, 32'h200);
    chk_cnt("sat_hi", 5, 1);
    resolve(32'h100, 1'b0, 32'h0, 1'b1);           // 11 -> 10
    chk_pred("dec1", 1'b1, 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h0, 1'b1);           // 10 -> 01
    chk_pred("dec2", 1'b1, 1'b0, 32'h200);
    chk_cnt("dec2", 7, 3);

    // invalid execute slot changes nothing, even with X payload
    @(negedge clk);
    bp_if.exValid       = 1'b0;
    bp_if.exIsBranch    = 1'b1;
    bp_if.exBranchTaken = 1'b1;
    bp_if.exPredTaken   = 1'b0;
    bp_if.exPc          = 32'h100;
    bp_if.exTarget      = 32'h999;
    @(posedge clk);
    @(negedge clk);
    bp_if.exIsBranch    = 1'bx;
    bp_if.exBranchTaken = 1'bx;
    bp_if.exPc          = 'x;
    bp_if.exTarget      = 'x;
    @(posedge clk);
    #1;
    bp_if.exIsBranch = 1'b0;
    chk_pred("ex_invalid", 1'b1, 1'b0, 32'h200);
    chk_cnt("ex_invalid", 7, 3);

    // floor: 01 -> 00 -> 00, then taken -> 01 (a wrap would read taken)
    resolve(32'h100, 1'b0, 32'h0, 1'b0);
    resolve(32'h100, 1'b0, 32'h0, 1'b0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0);
    chk_pred("sat_lo", 1'b1, 1'b0, 32'h200);
    chk_cnt("sat_lo", 10, 4);

    // alias: 0x200 shares idx 0 with tag 2; counter 01 -> 10
    resolve(32'h200, 1'b1, 32'h400, 1'b0);
    fetch(32'h100);
    chk_pred("alias_old", 1'b0, 1'b0, 32'h0);
    fetch(32'h200);
    chk_pred("alias_new", 1'b1, 1'b1, 32'h400);
    chk_cnt("alias", 11, 5);

    // not-taken never allocates a BTB entry
    resolve(32'h104, 1'b0, 32'h555, 1'b0);
    fetch(32'h104);
    chk_pred("nt_noalloc", 1'b0, 1'b0, 32'h0);
    chk_cnt("nt_noalloc", 12, 5);
`endif

    // asynchronous reset between edges clears everything immediately
    fetch(32'h100);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.target", bp_if.predTarget, 32'h0);
    chk_pred("async_rst", 1'b0, 1'b0, 32'h0);
    chk_cnt("async_rst", 0, 0);
    fetch(32'h200);
    chk("async_rst2.hit", {31'd0, bp_if.predHit}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_pred("post_rst", 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
